// File: rtl/unit_issue_responder_pkg.sv
// Shared types for the unit issue responder: queued request entry and FSM state.
// Operand/result and id widths are fixed here so every user of the entry type agrees.
package unit_issue_responder_pkg;

  localparam int XLEN = 32;
  localparam int ID_W = 3;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [2:0]      fn3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } unit_issue_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } unit_resp_state_t;

endpackage

// File: rtl/unit_issue_responder_fifo.sv
// In-order request queue for the unit issue responder.
// Pointers and count reset asynchronously; storage carries no reset.
module issue_request_fifo
  import unit_issue_responder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  unit_issue_entry_t push_data,
  input  logic              pop,
  output unit_issue_entry_t head,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  unit_issue_entry_t mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/unit_issue_responder.sv
// Unit-side issue handshake: queues issued requests, runs them one at a time through
// a multicycle engine and returns results in issue order on the writeback handshake.
//
// state | meaning
// IDLE  | no op in flight, waiting for a queued request
// EXEC  | engine busy, eng_* held, waiting for eng_done
// WB    | result held on wb_*, waiting for wb_ack
module unit_issue_responder
  import unit_issue_responder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_new_request,
  input  logic [ID_W-1:0] issue_id,
  input  logic [2:0]      issue_fn3,
  input  logic [XLEN-1:0] issue_rs1,
  input  logic [XLEN-1:0] issue_rs2,
  output logic            issue_ready,
  output logic            eng_start,
  output logic [2:0]      eng_fn3,
  output logic [XLEN-1:0] eng_rs1,
  output logic [XLEN-1:0] eng_rs2,
  input  logic            eng_done,
  input  logic [XLEN-1:0] eng_result,
  output logic            wb_done,
  output logic [ID_W-1:0] wb_id,
  output logic [XLEN-1:0] wb_rd,
  input  logic            wb_ack
);

  unit_resp_state_t  state_q;
  unit_resp_state_t  state_d;
  unit_issue_entry_t push_entry;
  unit_issue_entry_t head;
  unit_issue_entry_t exec_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  assign push_entry = '{id: issue_id, fn3: issue_fn3, rs1: issue_rs1, rs2: issue_rs2};
  assign issue_ready = !fifo_full;
  assign push        = issue_new_request && issue_ready;

  issue_request_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (eng_done) state_d = WB;
      end
      WB: begin
        if (wb_ack) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The start cycle shows the queue head directly; exec_q holds it from the next cycle on.
  assign eng_start = pop;
  assign eng_fn3   = pop ? head.fn3 : exec_q.fn3;
  assign eng_rs1   = pop ? head.rs1 : exec_q.rs1;
  assign eng_rs2   = pop ? head.rs2 : exec_q.rs2;
  assign wb_done   = (state_q == WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      exec_q  <= '0;
      wb_id   <= '0;
      wb_rd   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) exec_q <= head;
      if (state_q == EXEC && eng_done) begin
        wb_id <= exec_q.id;
        wb_rd <= eng_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(issue_new_request && !issue_ready))
        else $warning("issue_new_request while issue_ready low, request dropped");
      assert (!(eng_done && state_q != EXEC))
        else $warning("eng_done outside EXEC ignored");
    end
  end

endmodule

// File: tb/tb_unit_issue_responder.sv
// Scoreboard bench for unit_issue_responder: directed requests push expected
// {id, result} entries, a monitor pops and compares on every wb handshake.
module tb_unit_issue_responder;
  import unit_issue_responder_pkg::*;

  logic            clk;
  logic            rst;
  logic            issue_new_request;
  logic [ID_W-1:0] issue_id;
  logic [2:0]      issue_fn3;
  logic [XLEN-1:0] issue_rs1;
  logic [XLEN-1:0] issue_rs2;
  logic            issue_ready;
  logic            eng_start;
  logic [2:0]      eng_fn3;
  logic [XLEN-1:0] eng_rs1;
  logic [XLEN-1:0] eng_rs2;
  logic            eng_done;
  logic [XLEN-1:0] eng_result;
  logic            wb_done;
  logic [ID_W-1:0] wb_id;
  logic [XLEN-1:0] wb_rd;
  logic            wb_ack;

  unit_issue_responder #(.DEPTH(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .issue_new_request (issue_new_request),
    .issue_id          (issue_id),
    .issue_fn3         (issue_fn3),
    .issue_rs1         (issue_rs1),
    .issue_rs2         (issue_rs2),
    .issue_ready       (issue_ready),
    .eng_start         (eng_start),
    .eng_fn3           (eng_fn3),
    .eng_rs1           (eng_rs1),
    .eng_rs2           (eng_rs2),
    .eng_done          (eng_done),
    .eng_result        (eng_result),
    .wb_done           (wb_done),
    .wb_id             (wb_id),
    .wb_rd             (wb_rd),
    .wb_ack            (wb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wb_seen = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Engine model: multiplies operands after eng_lat cycles, optional stall, killed by reset.
  logic            eng_done_m = 1'b0;
  logic [XLEN-1:0] eng_result_m = '0;
  logic            eng_done_f = 1'b0;
  logic            eng_stall = 1'b0;
  logic            eng_kill = 1'b0;
  int              eng_lat = 3;
  assign eng_done   = eng_done_m | eng_done_f;
  assign eng_result = eng_done_f ? 32'hdead_beef : eng_result_m;

  initial begin
    logic [XLEN-1:0] r;
    forever begin
      @(negedge clk);
      if (eng_start && !eng_kill) begin
        r = eng_rs1 * eng_rs2;
        repeat (eng_lat) @(posedge clk);
        while (eng_stall && !eng_kill) @(posedge clk);
        #1;
        if (!eng_kill) begin
          eng_done_m   = 1'b1;
          eng_result_m = r;
          @(posedge clk);
          #1;
          eng_done_m   = 1'b0;
        end
      end
    end
  end

  logic ack_en = 1'b1;
  always @(posedge clk) begin
    #1;
    wb_ack = ack_en && wb_done;
  end

  always @(negedge clk) begin
    if (!rst && wb_done && wb_ack) begin
      wb_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result_id", {29'd0, wb_id}, 32'hffff_ffff);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_id_order", {29'd0, wb_id}, {29'd0, e.id});
        chk("wb_rd", wb_rd, e.rd);
      end
    end
  end

  task automatic drv(input int id, input int a, input int b, input logic legal, input int rd);
    issue_new_request = 1'b1;
    issue_id  = ID_W'(id);
    issue_fn3 = 3'(id);
    issue_rs1 = XLEN'(a);
    issue_rs2 = XLEN'(b);
    if (legal) exp_q.push_back('{id: ID_W'(id), rd: XLEN'(rd)});
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || wb_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, (n < budget)}, 32'd1);
  endtask

  initial begin
    int n;
    logic [ID_W-1:0] hold_id;
    logic [XLEN-1:0] hold_rd;
    rst = 1'b1;
    issue_new_request = 1'b0;
    issue_id = '0;
    issue_fn3 = '0;
    issue_rs1 = '0;
    issue_rs2 = '0;
    wb_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst_eng_start", {31'd0, eng_start}, 32'd0);
    chk("rst_wb_done", {31'd0, wb_done}, 32'd0);
    chk("rst_wb_rd", wb_rd, 32'd0);
    chk("rst_eng_rs1", eng_rs1, 32'd0);
    next_cyc();
    rst = 1'b0;

    // Single op: start next cycle, done after 3 cycles, ack in the WB cycle.
    next_cyc();
    eng_lat = 3;
    drv(3, 5, 7, 1'b1, 35);
    next_cyc();
    issue_new_request = 1'b0;
    @(negedge clk);
    chk("t1_eng_start", {31'd0, eng_start}, 32'd1);
    chk("t1_eng_rs1", eng_rs1, 32'd5);
    chk("t1_eng_rs2", eng_rs2, 32'd7);
    chk("t1_eng_fn3", {29'd0, eng_fn3}, 32'd3);
    repeat (3) @(negedge clk);
    chk("t1_wb_done_exec", {31'd0, wb_done}, 32'd0);
    @(negedge clk);
    chk("t1_wb_done", {31'd0, wb_done}, 32'd1);
    chk("t1_wb_id", {29'd0, wb_id}, 32'd3);
    chk("t1_wb_rd", wb_rd, 32'd35);
    @(negedge clk);
    chk("t1_wb_done_fall", {31'd0, wb_done}, 32'd0);
    chk("t1_idle_no_start", {31'd0, eng_start}, 32'd0);

    // Fill with the engine stalled, then hold writeback off.
    eng_lat = 2;
    eng_stall = 1'b1;
    ack_en = 1'b0;
    next_cyc();
    drv(1, 2, 3, 1'b1, 6);
    @(negedge clk);
    chk("t2_ready_c0", {31'd0, issue_ready}, 32'd1);
    next_cyc();
    drv(2, 4, 5, 1'b1, 20);
    @(negedge clk);
    chk("t2_start_c1", {31'd0, eng_start}, 32'd1);
    chk("t2_rs1_c1", eng_rs1, 32'd2);
    next_cyc();
    drv(3, 6, 7, 1'b1, 42);
    @(negedge clk);
    chk("t2_ready_c2", {31'd0, issue_ready}, 32'd1);
    next_cyc();
    issue_new_request = 1'b0;
    @(negedge clk);
    chk("t2_ready_full", {31'd0, issue_ready}, 32'd0);
    chk("t2_no_start_exec", {31'd0, eng_start}, 32'd0);
    eng_stall = 1'b0;
    n = 0;
    while (!wb_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t3_wb_timeout", {31'd0, wb_done}, 32'd1);
    hold_id = wb_id;
    hold_rd = wb_rd;
    chk("t3_first_id", {29'd0, hold_id}, 32'd1);
    chk("t3_first_rd", hold_rd, 32'd6);
    for (int i = 0; i < 10; i++) begin
      chk("t3_wb_done_held", {31'd0, wb_done}, 32'd1);
      chk("t3_wb_id_held", {29'd0, wb_id}, {29'd0, hold_id});
      chk("t3_wb_rd_held", wb_rd, hold_rd);
      chk("t3_no_start", {31'd0, eng_start}, 32'd0);
      chk("t3_ready_low", {31'd0, issue_ready}, 32'd0);
      if (i < 9) @(negedge clk);
    end
    ack_en = 1'b1;
    @(negedge clk);
    chk("t4_ack_seen", {31'd0, wb_ack}, 32'd1);
    chk("t4_b2b_start", {31'd0, eng_start}, 32'd1);
    chk("t4_b2b_rs1", eng_rs1, 32'd4);
    chk("t4_b2b_rs2", eng_rs2, 32'd5);
    chk("t4_no_bypass_ready", {31'd0, issue_ready}, 32'd0);
    @(negedge clk);
    chk("t4_ready_after_pop", {31'd0, issue_ready}, 32'd1);
    drain("t4_drain_timeout", 60);

    // Protocol: illegal request while full is dropped.
    eng_stall = 1'b1;
    next_cyc();
    drv(4, 3, 3, 1'b1, 9);
    next_cyc();
    drv(5, 10, 10, 1'b1, 100);
    next_cyc();
    drv(6, 0, 8, 1'b1, 0);
    next_cyc();
    drv(7, 1, 1, 1'b0, 0);
    @(negedge clk);
    chk("t5_ready_full", {31'd0, issue_ready}, 32'd0);
    next_cyc();
    issue_new_request = 1'b0;
    @(negedge clk);
    chk("t5_ready_unchanged", {31'd0, issue_ready}, 32'd0);
    eng_stall = 1'b0;
    drain("t5_drain_timeout", 60);
    n = wb_seen;
    repeat (12) @(negedge clk);
    chk("t5_dropped_no_result", 32'(wb_seen - n), 32'd0);
    chk("t5_ready_empty", {31'd0, issue_ready}, 32'd1);

    // Stray eng_done in IDLE must not produce a result.
    next_cyc();
    eng_done_f = 1'b1;
    @(negedge clk);
    chk("t5_stray_no_start", {31'd0, eng_start}, 32'd0);
    next_cyc();
    eng_done_f = 1'b0;
    @(negedge clk);
    chk("t5_stray_no_wb", {31'd0, wb_done}, 32'd0);

    // Reset in the middle of EXEC with two requests queued.
    eng_stall = 1'b1;
    next_cyc();
    drv(1, 1, 2, 1'b0, 0);
    next_cyc();
    drv(2, 3, 4, 1'b0, 0);
    next_cyc();
    drv(6, 5, 6, 1'b0, 0);
    next_cyc();
    issue_new_request = 1'b0;
    @(negedge clk);
    chk("t6_full_before_rst", {31'd0, issue_ready}, 32'd0);
    chk("t6_exec_rs1", eng_rs1, 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    eng_kill = 1'b1;
    #1;
    chk("t6_rst_ready", {31'd0, issue_ready}, 32'd1);
    chk("t6_rst_start", {31'd0, eng_start}, 32'd0);
    chk("t6_rst_wb_done", {31'd0, wb_done}, 32'd0);
    chk("t6_rst_eng_rs1", eng_rs1, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    eng_kill = 1'b0;
    eng_stall = 1'b0;
    next_cyc();
    drv(5, 9, 3, 1'b1, 27);
    next_cyc();
    issue_new_request = 1'b0;
    drain("t6_drain_timeout", 40);
    @(negedge clk);
    chk("t6_end_idle_wb", {31'd0, wb_done}, 32'd0);
    chk("t6_end_ready", {31'd0, issue_ready}, 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
